// File: rtl/auc_pkg.sv
// rtl/auc_pkg.sv - shared types and constants for the arithmetic-unit issue stage
package auc_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int OP_W_DEF  = 3;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_HOLD   = 2'b10
  } state_t;

  // Opcodes decoded by the nand2 core; passed through here untouched.
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
endpackage

// File: rtl/auc_settle_cnt.sv
// rtl/auc_settle_cnt.sv - loadable down-counter timing the core settle window
module auc_settle_cnt
  import auc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/auc_issue_ctrl.sv
// rtl/auc_issue_ctrl.sv - issue operands to the combinational core, wait, capture result
module auc_issue_ctrl
  import auc_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int OP_W          = OP_W_DEF,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_chain,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  output logic [OP_W-1:0]  core_op,
  input  logic [WIDTH-1:0] core_y,
  input  logic             core_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_c,
  output logic             out_z,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic             accept, capture, cnt_zero;
  logic [WIDTH-1:0] last_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  auc_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (LOAD_VAL),
    .dec      (state == ST_SETTLE),
    .zero     (cnt_zero)
  );

  // Operands stay frozen on the core from acceptance until the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_a  <= '0;
      core_b  <= '0;
      core_op <= '0;
    end else if (accept) begin
      core_a  <= in_chain ? last_y : in_a;
      core_b  <= in_b;
      core_op <= in_op;
    end
  end

  // Zero flag is registered with the result so it never tracks the live core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_y  <= '0;
      out_c  <= 1'b0;
      out_z  <= 1'b1;
      last_y <= '0;
    end else if (capture) begin
      out_y  <= core_y;
      out_c  <= core_cout;
      out_z  <= (core_y == '0);
      last_y <= core_y;
    end
  end

endmodule

// File: doc/auc_issue_ctrl.md
Name: auc_issue_ctrl

Overview:
- Sequential issue/capture stage wrapped around the gate-level 4-bit arithmetic core, which is built from nand2 cells and is purely combinational.
- Accepts operand/opcode transactions on a valid/ready handshake and drives the operands onto the core.
- Waits a programmable number of settle cycles, then captures the core's result and carry into registers.
- Presents the result plus zero/carry flags on a downstream valid/ready handshake. Supports chained operation, where the previous result is used as operand A.

Parameters:
- WIDTH, 4, data width of operands and result.
- OP_W, 3, width of opcode passed through to the core.
- SETTLE_CYCLES, 2, cycles allowed for the combinational core to settle; legal range 1..15.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers a transaction.
- in_ready  output  1  block accepts a transaction this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  OP_W  opcode.
- in_chain  input  1  1 = use last captured result as A, ignoring in_a.
- core_a  output  WIDTH  registered operand A to the core.
- core_b  output  WIDTH  registered operand B to the core.
- core_op  output  OP_W  registered opcode to the core.
- core_y  input  WIDTH  core result.
- core_cout  input  1  core carry-out.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_y  output  WIDTH  captured result.
- out_c  output  1  captured carry.
- out_z  output  1  1 when out_y == 0.
- busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset: async assert when rst_n=0; deassertion is taken synchronously by the design.
  - State = IDLE.
  - core_a, core_b, core_op, out_y, out_c and the last-result register = 0.
  - out_z = 1, out_valid = 0, in_ready = 1 (combinational from state), busy = 0.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register core_a, core_b and core_op. core_a = last_y if in_chain, else in_a.
  - Load settle counter with SETTLE_CYCLES-1, then go to SETTLE.
- SETTLE:
  - in_ready = 0 and core_* are held stable.
  - Counter decrements each cycle.
  - On the cycle the counter is 0, register out_y = core_y, out_c = core_cout and last_y = core_y, then go to HOLD.
  - Latency from the accepting edge to out_valid=1 is exactly SETTLE_CYCLES+1 edges; with SETTLE_CYCLES=2, out_valid rises on the 3rd edge after acceptance.
- HOLD:
  - out_valid = 1; out_y, out_c and out_z are stable.
  - On out_valid & out_ready, go to IDLE and clear out_valid.
  - in_ready becomes 1 in the next cycle. There is no same-cycle bypass, so max throughput is one transaction per SETTLE_CYCLES+2 cycles.
- out_z is registered together with out_y, never computed from the live core_y.
- Backpressure: out_ready held 0 keeps HOLD indefinitely with all outputs constant; in_valid is ignored meanwhile.
- in_chain on the first transaction after reset uses last_y = 0.
- in_valid while not in IDLE: no effect. Upstream must hold its data until in_ready.
- Reset mid-SETTLE or mid-HOLD: immediate return to reset values; a pending result is discarded and last_y is cleared.
- Settle counter width is 4 bits. SETTLE_CYCLES=1 means the counter loads 0 and capture happens on the first SETTLE cycle.
- All arithmetic is performed by the core. This block does no width extension, and out_y is exactly WIDTH bits.

Decomposition:
- Shared package auc_pkg:
  - state enum (IDLE/SETTLE/HOLD, 2-bit encoding 00/01/10);
  - WIDTH default constant;
  - opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_NAND=3, OP_OR=4, OP_XOR=5. These are shared with the core; this block passes them through unmodified.
- One natural sub-module: auc_settle_cnt, a loadable 4-bit down-counter with a zero flag.
- FSM and capture registers stay in auc_issue_ctrl.

Test Plan:
- Reset with in_valid=1 asserted at the same time → in_ready=1, out_valid=0, out_z=1, out_y=0; the transaction is not accepted until rst_n=1.
- Accept a=4'h3, b=4'h5, op=OP_ADD; core model returns 4'h8, cout=0 → out_valid rises exactly 3 edges after acceptance; out_y=8, out_c=0, out_z=0; core_a/core_b held stable throughout SETTLE.
- Accept a=4'hF, b=4'h1, op=OP_ADD (core 0, cout=1) → out_y=0, out_c=1, out_z=1. Then in_chain=1, b=4'h2 → core_a=0, and in_a=4'h9 is ignored.
- Hold out_ready=0 for 10 cycles in HOLD while toggling in_valid → outputs constant, in_ready=0, no new capture; on out_ready=1, in_ready=1 on the following cycle.
- Assert rst_n=0 on the 2nd SETTLE cycle → all outputs return immediately to reset values; the next chained transaction uses core_a=0.
- SETTLE_CYCLES=1 build → out_valid 2 edges after acceptance; back-to-back transactions accepted at a 3-cycle period with out_ready tied 1.
